// File: rtl/alt_eyemon_remap_rom.sv
// Eye-monitor phase-step remap: logical code <-> physical DPRIO code.
// Forward table is binary-to-Gray; inverse table is Gray-to-binary.
module alt_eyemon_remap_rom #(
  parameter int REG_OUT = 1
) (
  input  logic       i_avmm_clk,
  input  logic       i_resetn,
  input  logic [5:0] i_addr,
  output logic [5:0] o_data,
  input  logic [5:0] i_inv_addr,
  output logic [5:0] o_inv_data
);

  localparam logic [5:0] FWD_ROM [64] = '{
    6'h00, 6'h01, 6'h03, 6'h02,
    6'h06, 6'h07, 6'h05, 6'h04,
    6'h0C, 6'h0D, 6'h0F, 6'h0E,
    6'h0A, 6'h0B, 6'h09, 6'h08,
    6'h18, 6'h19, 6'h1B, 6'h1A,
    6'h1E, 6'h1F, 6'h1D, 6'h1C,
    6'h14, 6'h15, 6'h17, 6'h16,
    6'h12, 6'h13, 6'h11, 6'h10,
    6'h30, 6'h31, 6'h33, 6'h32,
    6'h36, 6'h37, 6'h35, 6'h34,
    6'h3C, 6'h3D, 6'h3F, 6'h3E,
    6'h3A, 6'h3B, 6'h39, 6'h38,
    6'h28, 6'h29, 6'h2B, 6'h2A,
    6'h2E, 6'h2F, 6'h2D, 6'h2C,
    6'h24, 6'h25, 6'h27, 6'h26,
    6'h22, 6'h23, 6'h21, 6'h20
  };

  // Exact inverse of FWD_ROM, entry by entry.
  localparam logic [5:0] INV_ROM [64] = '{
    6'h00, 6'h01, 6'h03, 6'h02,
    6'h07, 6'h06, 6'h04, 6'h05,
    6'h0F, 6'h0E, 6'h0C, 6'h0D,
    6'h08, 6'h09, 6'h0B, 6'h0A,
    6'h1F, 6'h1E, 6'h1C, 6'h1D,
    6'h18, 6'h19, 6'h1B, 6'h1A,
    6'h10, 6'h11, 6'h13, 6'h12,
    6'h17, 6'h16, 6'h14, 6'h15,
    6'h3F, 6'h3E, 6'h3C, 6'h3D,
    6'h38, 6'h39, 6'h3B, 6'h3A,
    6'h30, 6'h31, 6'h33, 6'h32,
    6'h37, 6'h36, 6'h34, 6'h35,
    6'h20, 6'h21, 6'h23, 6'h22,
    6'h27, 6'h26, 6'h24, 6'h25,
    6'h2F, 6'h2E, 6'h2C, 6'h2D,
    6'h28, 6'h29, 6'h2B, 6'h2A
  };

  logic [5:0] w_fwd;
  logic [5:0] w_inv;

  assign w_fwd = FWD_ROM[i_addr];
  assign w_inv = INV_ROM[i_inv_addr];

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [5:0] r_data;
      logic [5:0] r_inv_data;

      always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
        if (!i_resetn) begin
          r_data     <= 6'h00;
          r_inv_data <= 6'h00;
        end else begin
          r_data     <= w_fwd;
          r_inv_data <= w_inv;
        end
      end

      assign o_data     = r_data;
      assign o_inv_data = r_inv_data;
    end else begin : g_comb
      assign o_data     = w_fwd;
      assign o_inv_data = w_inv;
    end
  endgenerate

endmodule

// File: tb/tb_alt_eyemon_remap_rom.sv
// Directed bench for alt_eyemon_remap_rom, registered and
// combinational builds side by side.
module tb_alt_eyemon_remap_rom;

  logic       clk;
  logic       rst_n;
  logic [5:0] addr;
  logic [5:0] inv_addr;
  logic [5:0] data;
  logic [5:0] inv_data;
  logic [5:0] c_addr;
  logic [5:0] c_inv_addr;
  logic [5:0] c_data;
  logic [5:0] c_inv_data;

  int n_chk;
  int n_fail;

  alt_eyemon_remap_rom #(.REG_OUT(1)) u_reg (
    .i_avmm_clk (clk),
    .i_resetn   (rst_n),
    .i_addr     (addr),
    .o_data     (data),
    .i_inv_addr (inv_addr),
    .o_inv_data (inv_data)
  );

  alt_eyemon_remap_rom #(.REG_OUT(0)) u_comb (
    .i_avmm_clk (clk),
    .i_resetn   (rst_n),
    .i_addr     (c_addr),
    .o_data     (c_data),
    .i_inv_addr (c_inv_addr),
    .o_inv_data (c_inv_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] gray(input logic [5:0] x);
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag,
                       input logic [5:0] obs,
                       input logic [5:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] k6;
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    addr       = 6'h15;
    inv_addr   = 6'h15;
    c_addr     = 6'h00;
    c_inv_addr = 6'h00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_data", data, 6'h00);
    check("rst_async_inv", inv_data, 6'h00);
    repeat (3) tick();
    check("rst_hold_data", data, 6'h00);
    check("rst_hold_inv", inv_data, 6'h00);

    rst_n    = 1'b1;
    addr     = 6'h05;
    inv_addr = 6'h07;
    #1;
    check("pre_edge_data", data, 6'h00);
    tick();
    check("fwd_05", data, 6'h07);
    check("inv_07", inv_data, 6'h05);

    addr     = 6'h3F;
    inv_addr = 6'h20;
    tick();
    check("fwd_3F", data, 6'h20);
    check("inv_20", inv_data, 6'h3F);

    addr     = 6'h2A;
    inv_addr = 6'h3F;
    tick();
    check("fwd_2A", data, 6'h3F);
    check("inv_3F", inv_data, 6'h2A);

    addr     = 6'h00;
    inv_addr = 6'h00;
    tick();
    check("fwd_00", data, 6'h00);
    check("inv_00", inv_data, 6'h00);

    addr = 6'h15;
    tick();
    check("indep_fwd_15", data, 6'h1F);
    check("indep_inv_hold", inv_data, 6'h00);

    // Mid-stream reset: the pending lookup must never surface.
    addr     = 6'h2A;
    inv_addr = 6'h2A;
    tick();
    check("pre_rst_data", data, 6'h3F);
    addr     = 6'h15;
    inv_addr = 6'h15;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_data", data, 6'h00);
    check("mid_rst_inv", inv_data, 6'h00);
    tick();
    check("mid_rst_hold", data, 6'h00);
    rst_n    = 1'b1;
    addr     = 6'h01;
    inv_addr = 6'h02;
    tick();
    check("post_rst_data", data, 6'h01);
    check("post_rst_inv", inv_data, 6'h03);

    for (int k = 0; k < 66; k++) begin
      if (k >= 2) begin
        k6 = 6'(k - 2);
        check("sweep_round", inv_data, k6);
      end
      if (k >= 1 && k <= 64) begin
        k6 = 6'(k - 1);
        check("sweep_fwd", data, gray(k6));
      end
      inv_addr = data;
      addr     = 6'(k);
      tick();
    end

    #1;
    c_addr     = 6'h05;
    c_inv_addr = 6'h07;
    #1;
    check("comb_fwd_05", c_data, 6'h07);
    check("comb_inv_07", c_inv_data, 6'h05);
    c_addr = 6'h3F;
    #1;
    check("comb_fwd_3F", c_data, 6'h20);
    check("comb_indep", c_inv_data, 6'h05);
    c_inv_addr = 6'h20;
    rst_n      = 1'b0;
    #1;
    check("comb_rst_inv", c_inv_data, 6'h3F);
    check("comb_rst_fwd", c_data, 6'h20);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_eyemon_remap_rom.md
ALT_EYEMON_REMAP_ROM -- requirements
Module: alt_eyemon_remap_rom

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_avmm_clk clocks the block and i_resetn resets it.
REQ-002 Parameter REG_OUT, default 1, SHALL select registered outputs (1) or combinational outputs (0).
REQ-003 Port i_avmm_clk  input  1  SHALL be the clock; all registers sample on its rising edge.
REQ-004 Port i_resetn  input  1  SHALL be the asynchronous active-low reset.
REQ-005 Port i_addr  input  6  SHALL be the forward-map lookup address (logical phase-step code).
REQ-006 Port o_data  output  6  SHALL be the forward-map result (physical DPRIO code).
REQ-007 Port i_inv_addr  input  6  SHALL be the inverse-map lookup address (physical DPRIO code read back).
REQ-008 Port o_inv_data  output  6  SHALL be the inverse-map result (logical code).

Function
REQ-009 The forward map SHALL be the 6-bit binary-to-Gray conversion: f(x) = x XOR (x >> 1).
REQ-010 The inverse map SHALL be the Gray-to-binary conversion: g(y)[5] = y[5], and g(y)[k] = g(y)[k+1] XOR y[k] for k = 4 down to 0.
REQ-011 Both maps SHALL be implemented as fully enumerated 64-entry constant tables, one per map, with no arithmetic in the datapath.
REQ-012 g(f(x)) SHALL equal x, and f(g(y)) SHALL equal y, for all 64 codes; both tables SHALL be bijective.
REQ-013 The two lookups SHALL be independent and concurrent; a change on one address SHALL NOT affect the other output.
REQ-014 With REG_OUT=1, o_data SHALL equal f(i_addr sampled at the previous rising edge): latency of 1 cycle, updated every cycle, no enable.
REQ-015 With REG_OUT=1, o_inv_data SHALL equal g(i_inv_addr sampled at the previous rising edge): latency of 1 cycle.
REQ-016 With REG_OUT=0, the outputs SHALL be purely combinational (latency 0), and i_avmm_clk and i_resetn SHALL have no effect on them.
REQ-017 The block SHALL have no handshake and no state machine; every address value is legal, and no input value produces an X or undefined output.
REQ-018 Boundary codes SHALL map as follows: f(0x00)=0x00, f(0x3F)=0x20, g(0x00)=0x00, g(0x20)=0x3F.

Reset
REQ-019 With REG_OUT=1, asserting i_resetn low SHALL immediately and asynchronously force o_data=0x00 and o_inv_data=0x00, independent of the clock.
REQ-020 While i_resetn is low, the output registers SHALL hold 0x00 regardless of the addresses or clock edges.
REQ-021 After i_resetn deasserts, the first rising edge SHALL load the lookup results of the addresses present at that edge.
REQ-022 If reset asserts mid-stream, pending lookups SHALL be discarded; no result from before reset SHALL appear after release.
REQ-023 The power-up value of the output registers SHALL be 0x00.

Verification
REQ-024 With REG_OUT=1, the bench SHALL drive reset low with i_addr=0x15 while clocking, and check that o_data=0x00 and o_inv_data=0x00.
REQ-025 The bench SHALL release reset, drive i_addr=0x05 and i_inv_addr=0x07, and check after 1 edge that o_data=0x07 and o_inv_data=0x05.
REQ-026 The bench SHALL drive i_addr=0x3F and i_inv_addr=0x20, and check after 1 edge that o_data=0x20 and o_inv_data=0x3F.
REQ-027 The bench SHALL drive i_addr=0x2A and i_inv_addr=0x3F, and check after 1 edge that o_data=0x3F and o_inv_data=0x2A.
REQ-028 The bench SHALL sweep i_addr over 0x00..0x3F with i_inv_addr set to the o_data value of the previous cycle, and check that o_inv_data returns the original address 2 cycles later, for all 64 codes.
REQ-029 The bench SHALL repeat REQ-025 with REG_OUT=0, and check that both results appear combinationally with no clock edge.
